// File: rtl/e_slot_alloc.sv
// e_slot_alloc: round-robin slot ID allocator with occupancy tracking and error flag.
// Candidate is the first free slot scanning down from ptr-1 circularly, via a radix-grouped search.
module e_slot_alloc #(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 alloc_rdy_i,
    output logic                 alloc_vld_o,
    output logic [$clog2(W)-1:0] alloc_id_o,
    input  logic                 free_vld_i,
    input  logic [$clog2(W)-1:0] free_id_i,
    input  logic                 flush_i,
    output logic [W-1:0]         occ_o,
    output logic [$clog2(W):0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 err_o
);
    localparam int AW = $clog2(W);
    localparam int CW = AW + 1;
    localparam int NG = (W + RADIX_N - 1) / RADIX_N;
    localparam int PW = NG * RADIX_N;

    logic [W-1:0]       occ_q, occ_d;
    logic [AW-1:0]      ptr_q, ptr_d, cand;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [PW-1:0]      rot;
    logic [NG-1:0]      grp_zero;
    logic [RADIX_N-1:0] sub;
    logic               grant, free_ok;
    int                 sel_g, off;

    // rot[j] is the slot examined j-th; padding bits read as occupied
    always_comb begin
        rot = '1;
        for (int j = 0; j < W; j++) rot[j] = occ_q[AW'(ptr_q - AW'(1) - AW'(j))];
        for (int g = 0; g < NG; g++) grp_zero[g] = ~&rot[g*RADIX_N +: RADIX_N];
        sel_g = 0;
        for (int g = NG - 1; g >= 0; g--) if (grp_zero[g]) sel_g = g;
        sub = rot[sel_g*RADIX_N +: RADIX_N];
        off = 0;
        for (int k = RADIX_N - 1; k >= 0; k--) if (!sub[k]) off = k;
        cand = AW'(ptr_q - AW'(1) - AW'(sel_g * RADIX_N + off));
    end

    assign alloc_vld_o = ~full_o;
    assign alloc_id_o  = cand;
    assign grant       = alloc_vld_o & alloc_rdy_i;
    assign occ_o       = occ_q;
    assign count_o     = cnt_q;
    assign full_o      = cnt_q == CW'(W);
    assign empty_o     = cnt_q == '0;
    assign err_o       = err_q;

    always_comb begin
        free_ok = free_vld_i & occ_q[free_id_i];
        occ_d   = occ_q;
        if (grant) occ_d[cand] = 1'b1;
        if (free_ok) occ_d[free_id_i] = 1'b0;
        cnt_d = cnt_q + CW'(grant) - CW'(free_ok);
        ptr_d = grant ? cand : ptr_q;
        err_d = err_q | (free_vld_i & ~occ_q[free_id_i]);
        if (flush_i) begin
            occ_d = '0;
            cnt_d = '0;
            ptr_d = '0;
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_e_slot_alloc.sv
// tb_e_slot_alloc: directed scenarios plus random traffic against a slot-list reference model.
module tb_e_slot_alloc;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_rdy = 1'b0, free_vld = 1'b0, flush = 1'b0;
    logic [2:0] free_id = '0;
    logic       alloc_vld, full, empty, err;
    logic [2:0] alloc_id;
    logic [7:0] occ;
    logic [3:0] count;

    int n_cmp = 0, n_bad = 0;
    bit m_occ[W];
    int m_ptr;
    bit m_err;

    e_slot_alloc #(.W(W), .RADIX_N(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .alloc_rdy_i(alloc_rdy), .alloc_vld_o(alloc_vld),
        .alloc_id_o(alloc_id), .free_vld_i(free_vld), .free_id_i(free_id), .flush_i(flush),
        .occ_o(occ), .count_o(count), .full_o(full), .empty_o(empty), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < W; i++) c += m_occ[i];
        return c;
    endfunction

    function automatic int m_cand();
        for (int k = 1; k <= W; k++) if (!m_occ[(m_ptr - k + W) % W]) return (m_ptr - k + W) % W;
        return -1;
    endfunction

    function automatic logic [7:0] m_vec();
        logic [7:0] v;
        for (int i = 0; i < W; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < W; i++) m_occ[i] = 0;
        m_ptr = 0;
        m_err = 0;
    endtask

    task automatic check_all();
        chk("vld", alloc_vld, m_count() < W);
        if (m_count() < W) chk("id", alloc_id, m_cand());
        chk("occ", occ, m_vec());
        chk("count", count, m_count());
        chk("full", full, m_count() == W);
        chk("empty", empty, m_count() == 0);
        chk("err", err, m_err);
    endtask

    // called at a falling edge; checks outputs, applies inputs, advances model over next rising edge
    task automatic step(input logic rdy, input logic fv, input int fid, input logic fl);
        bit g, ok;
        int c;
        check_all();
        alloc_rdy = rdy; free_vld = fv; free_id = 3'(fid); flush = fl;
        c  = m_cand();
        g  = rdy && m_count() < W;
        ok = fv && m_occ[fid];
        if (fl) begin
            for (int i = 0; i < W; i++) m_occ[i] = 0;
            m_ptr = 0;
        end else begin
            if (fv && !ok) m_err = 1;
            if (g) begin m_occ[c] = 1; m_ptr = c; end
            if (ok) m_occ[fid] = 0;
        end
        @(negedge clk);
        alloc_rdy = 0; free_vld = 0; flush = 0;
    endtask

    initial begin
        int q[$];
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("rst_id", alloc_id, 7);
        // drain from reset
        repeat (9) step(1, 0, 0, 0);
        chk("drain_full", full, 1);
        // wrap: free 5 then regrant it
        step(0, 1, 5, 0);
        chk("wrap_id", alloc_id, 5);
        step(1, 0, 0, 0);
        chk("wrap_full", full, 1);
        // rotation skip
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 7, 0);
        chk("rot_id", alloc_id, 5);
        repeat (7) step(1, 0, 0, 0);
        // simultaneous free/grant
        step(1, 1, 3, 0);
        chk("sim_cnt1", count, 7);
        step(1, 1, 2, 0);
        chk("sim_cnt2", count, 7);
        // errors then flush
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);
        chk("err_set", err, 1);
        step(0, 0, 0, 1);
        chk("flush_id", alloc_id, 7);
        chk("flush_err", err, 1);
        // async reset mid-burst
        repeat (3) step(1, 0, 0, 0);
        alloc_rdy = 1;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("ar_vld", alloc_vld, 1);
        chk("ar_id", alloc_id, 7);
        chk("ar_occ", occ, 0);
        chk("ar_cnt", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_err", err, 0);
        m_reset();
        @(negedge clk);
        alloc_rdy = 0;
        rst_n = 1;
        step(1, 0, 0, 0);
        chk("ar_first", occ, 8'h80);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int fid;
            q = {};
            for (int i = 0; i < W; i++) if (m_occ[i]) q.push_back(i);
            fid = (q.size() > 0 && $urandom_range(15) != 0) ? q[$urandom_range(q.size() - 1)]
                                                             : int'($urandom_range(W - 1));
            step($urandom_range(3) != 0, $urandom_range(2) == 0, fid, $urandom_range(63) == 0);
        end
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/e_slot_alloc.md
# e_slot_alloc

Circular slot allocator that owns a W-entry occupancy vector and hands out free slot IDs in round-robin order. Each grant is chosen by a circular first-zero search that starts just below a registered rotating pointer. Consumers later return the ID through a free port. The block sits between request-generating front-end logic and any tag-indexed storage, such as a reorder table or response buffer, that needs unique in-flight IDs.

## Interface
- W, 32: number of slots; power of two, ≥4.
- RADIX_N, 4: group radix of the internal first-zero search tree; range [4,8]. Affects timing only, never function.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- alloc_rdy_i  in  1  consumer accepts the presented ID this cycle.
- alloc_vld_o  out  1  a free slot is available; alloc_id_o is valid.
- alloc_id_o  out  $clog2(W)  ID of the slot offered for allocation.
- free_vld_i  in  1  return the slot given by free_id_i.
- free_id_i  in  $clog2(W)  ID being returned.
- flush_i  in  1  synchronous clear of all occupancy.
- occ_o  out  W  current occupancy vector; bit i = 1 means slot i is allocated.
- count_o  out  $clog2(W)+1  number of allocated slots.
- full_o  out  1  count_o == W.
- empty_o  out  1  count_o == 0.
- err_o  out  1  sticky protocol-violation flag.

## Operation
- State:
  - occ[W-1:0]
  - ptr[$clog2(W)-1:0]
  - cnt[$clog2(W):0]
  - err
- Reset values: occ=0, ptr=0, cnt=0, err=0.
- Outputs out of reset: alloc_vld_o=1, alloc_id_o=W-1, occ_o=0, count_o=0, full_o=0, empty_o=1, err_o=0.
- Search:
  - Candidate = first 0 in occ, scanning descending from bit ptr-1 (mod W), circularly.
  - Bit ptr itself is examined last.
  - Example, W=16, ptr=8: scan order is 7..0, then 15..8.
- alloc_vld_o = ~full. alloc_id_o = candidate. Both are a pure function of registered state, with no combinational path from any input.
- Grant = alloc_vld_o & alloc_rdy_i. On the next edge after a grant:
  - occ[id] ← 1
  - ptr ← id
  - cnt increments
- alloc_rdy_i while alloc_vld_o=0 is ignored: no state change, no error.
- Free = free_vld_i. On the next edge after a free:
  - occ[free_id_i] ← 0
  - cnt decrements
- A freed slot becomes visible to the search only from the following cycle; there is no same-cycle bypass.
- Free of a slot with occ[free_id_i]=0: state unchanged, err ← 1.
- Grant and free in the same cycle:
  - Both apply. cnt is unchanged.
  - The two IDs cannot collide legally, because a granted slot is by definition unoccupied. Such a collision is caught by the error rule above.
- Free while full, with alloc_rdy_i=1: no grant that cycle, because alloc_vld_o=0. The slot is grantable the next cycle.
- flush_i has priority over grant and free:
  - occ ← 0, cnt ← 0, ptr ← 0.
  - err is unchanged; err clears only on reset.
- Invariant: cnt == popcount(occ) at all times.

## Timing
- Grant-to-occupancy latency: 1 cycle. occ_o, count_o, full_o and empty_o reflect a grant or free on the edge that follows it.
- Back-to-back grants every cycle are sustained until full. Each new candidate is derived from the updated ptr and occ.
- Free-to-reallocatable latency: 1 cycle.
- Reset mid-operation: all state returns asynchronously to reset values. Any grant in flight that cycle is lost, and consumers must discard outstanding IDs.
- The search is a single combinational stage between registers. Its depth is about log_RADIX_N(2W) levels.

## Test plan
- Post-reset drain, W=8: hold alloc_rdy_i=1 for 9 cycles.
  - Required: IDs 7,6,5,4,3,2,1,0 on consecutive cycles.
  - Then alloc_vld_o=0, full_o=1, count_o=8.
- Wrap: W=8, allocate 7..0, free ID 5, then assert alloc_rdy_i.
  - Required: one cycle later alloc_vld_o=1 with alloc_id_o=5. After the grant, full_o=1.
- Rotation skip: W=8, allocate 7 and 6, free 7, allocate again.
  - Required: ID 5, because the search starts at ptr-1=5. Then 4,3,2,1,0, then 7.
- Simultaneous events:
  - Full W=8, free 3 with alloc_rdy_i=1: no grant, count_o=7.
  - Next cycle, free 2 and grant 3 together: count_o stays 7.
- Errors and flush:
  - Free an unoccupied ID 4: err_o=1 next cycle and occ unchanged.
  - Then flush_i: occ_o=0, count_o=0, alloc_id_o=7, err_o remains 1.
- Async reset mid-burst: assert rst_n_i low between edges.
  - Required: all outputs take reset values immediately.
  - After release, the first grant is ID W-1.
